// File: rtl/round_controller.sv
// round_controller: match/round sequencer - KO and timeout detection, round wins, match result.
// Build option ROUND_PAUSE_EN adds a pause input that freezes FIGHT and ROUND_END.
module round_controller #(
  parameter int TICK_DIV      = 50_000_000,
  parameter int ROUND_SECONDS = 60,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int MAX_ROUNDS    = 5,
  parameter int PAUSE_SECONDS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef ROUND_PAUSE_EN
  input  logic       pause,
`endif
  input  logic [2:0] p1_health,
  input  logic [2:0] p2_health,
  input  logic [2:0] p1_block,
  input  logic [2:0] p2_block,
  output logic       fight_active,
  output logic       round_reset,
  output logic       ko,
  output logic [6:0] timer,
  output logic [2:0] round_num,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic [1:0] round_winner,
  output logic       match_over,
  output logic [1:0] match_winner
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_FIGHT = 3'd2;
  localparam logic [2:0] S_END   = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] presc;
  logic [6:0]    secs;
  logic          first;
  logic          hold;
  logic          wrap;
  logic          ko1;
  logic          ko2;
  logic          ko_hit;
  logic          fight_done;
  logic          match_end;
  logic [1:0]    kw;
  logic [1:0]    tw;
  logic [1:0]    fin;
  logic [1:0]    mw;

`ifdef ROUND_PAUSE_EN
  assign hold = pause && (state == S_FIGHT || state == S_END);
`else
  assign hold = 1'b0;
`endif

  // health 4..7 is tracker underflow and counts as knocked out
  assign ko1 = p1_health[2] | ~|p1_health;
  assign ko2 = p2_health[2] | ~|p2_health;

  assign wrap   = presc == PW'(TICK_DIV - 1);
  assign ko_hit = (state == S_FIGHT) && !first && !hold && (ko1 || ko2);

  assign fight_active = (state == S_FIGHT) && !hold;
  assign round_reset  = state == S_INIT;
  assign ko           = ko_hit;
  assign match_over   = state == S_OVER;

  assign match_end = (p1_wins >= 2'(ROUNDS_TO_WIN))
                  || (p2_wins >= 2'(ROUNDS_TO_WIN))
                  || (round_num == 3'(MAX_ROUNDS));

  always_comb begin
    kw = ko1 ? (ko2 ? 2'b11 : 2'b10) : 2'b01;
    tw = 2'b11;
    if (p1_health != p2_health)
      tw = (p1_health > p2_health) ? 2'b01 : 2'b10;
    else if (p1_block != p2_block)
      tw = (p1_block > p2_block) ? 2'b01 : 2'b10;
    fin = ko_hit ? kw : tw;
    fight_done = ko_hit || (wrap && timer <= 7'd1);
    mw = 2'b11;
    if (p1_wins != p2_wins)
      mw = (p1_wins > p2_wins) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      presc        <= '0;
      secs         <= '0;
      first        <= 1'b0;
      timer        <= 7'(ROUND_SECONDS);
      round_num    <= '0;
      p1_wins      <= '0;
      p2_wins      <= '0;
      round_winner <= '0;
      match_winner <= '0;
    end else if (!hold) begin
      unique case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state        <= S_INIT;
            round_num    <= 3'd1;
            p1_wins      <= '0;
            p2_wins      <= '0;
            round_winner <= '0;
            match_winner <= '0;
          end
        end
        S_INIT: begin
          state <= S_FIGHT;
          timer <= 7'(ROUND_SECONDS);
          presc <= '0;
          first <= 1'b1;
        end
        S_FIGHT: begin
          first <= 1'b0;
          presc <= wrap ? '0 : presc + PW'(1);
          if (wrap && !ko_hit)
            timer <= timer - 7'd1;
          if (fight_done) begin
            state        <= S_END;
            presc        <= '0;
            secs         <= '0;
            round_winner <= fin;
            if (fin == 2'b01 && p1_wins != 2'd3)
              p1_wins <= p1_wins + 2'd1;
            if (fin == 2'b10 && p2_wins != 2'd3)
              p2_wins <= p2_wins + 2'd1;
          end
        end
        S_END: begin
          presc <= wrap ? '0 : presc + PW'(1);
          if (wrap) begin
            secs <= secs + 7'd1;
            if (secs == 7'(PAUSE_SECONDS - 1)) begin
              if (match_end) begin
                state        <= S_OVER;
                match_winner <= mw;
              end else begin
                state     <= S_INIT;
                round_num <= round_num + 3'd1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Randomised scoreboard bench for round_controller.
// Stimulus predicts round, round-start and match results; a monitor pops and compares.
module tb_round_controller;

  localparam int TD = 4;
  localparam int RS = 3;
  localparam int PS = 1;
  localparam int RW = 2;
  localparam int MR = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] p1_health = 3'd3;
  logic [2:0] p2_health = 3'd3;
  logic [2:0] p1_block = 3'd3;
  logic [2:0] p2_block = 3'd3;
  logic       fight_active;
  logic       round_reset;
  logic       ko;
  logic [6:0] timer;
  logic [2:0] round_num;
  logic [1:0] p1_wins;
  logic [1:0] p2_wins;
  logic [1:0] round_winner;
  logic       match_over;
  logic [1:0] match_winner;

  round_controller #(
    .TICK_DIV(TD), .ROUND_SECONDS(RS), .ROUNDS_TO_WIN(RW),
    .MAX_ROUNDS(MR), .PAUSE_SECONDS(PS)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ROUND_PAUSE_EN
    .pause(pause),
`endif
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_block(p1_block), .p2_block(p2_block),
    .fight_active(fight_active), .round_reset(round_reset), .ko(ko),
    .timer(timer), .round_num(round_num),
    .p1_wins(p1_wins), .p2_wins(p2_wins),
    .round_winner(round_winner), .match_over(match_over),
    .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rw;
    int         w1;
    int         w2;
    bit         ko_chk;
    bit         ko_exp;
    int         len;
    bit         tmo;
  } res_t;

  typedef struct {
    int         rn;
    int         w1;
    int         w2;
    logic [1:0] rw;
  } init_t;

  typedef struct {
    logic [1:0] mw;
    int         rn;
  } mtch_t;

  res_t  res_q[$];
  init_t init_q[$];
  mtch_t mtch_q[$];

  int n_chk = 0;
  int n_fail = 0;
  bit mon_off = 1'b0;

  int w1;
  int w2;
  int rn;
  logic [1:0] last_rw;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic abort(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
    finish_test();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ko_val();
    int v;
    v = $urandom_range(3, 7);
    return (v == 3) ? 3'd0 : 3'(v);
  endfunction

  function automatic logic [1:0] judge(int h1, int h2, int b1, int b2);
    if (h1 != h2) return (h1 > h2) ? 2'b01 : 2'b10;
    if (b1 != b2) return (b1 > b2) ? 2'b01 : 2'b10;
    return 2'b11;
  endfunction

  // kind: 0 P1 KOs P2, 1 P2 KOs P1, 2 double KO, 3 random timeout, 4 tied timeout
  task automatic run_round(input int kind, output bit done);
    res_t  r;
    init_t ir;
    mtch_t mr;
    int    k;
    int    d;
    int    h1;
    int    h2;
    int    b1;
    int    b2;
    k = 0;
    while (!fight_active && k < 20) begin
      tick();
      k++;
    end
    if (!fight_active) abort("fight_start");
    if ($urandom_range(0, 3) == 0) start = 1'b1;
    if (kind <= 2) begin
      d = $urandom_range(0, 11);
      repeat (d) tick();
      r.rw = (kind == 0) ? 2'b01 : (kind == 1) ? 2'b10 : 2'b11;
      r.len = (d == 0) ? 2 : d + 1;
      r.ko_chk = (kind != 2);
      r.ko_exp = 1'b1;
      r.tmo = 1'b0;
      if (r.rw == 2'b01) w1 = (w1 < 3) ? w1 + 1 : 3;
      if (r.rw == 2'b10) w2 = (w2 < 3) ? w2 + 1 : 3;
      r.w1 = w1;
      r.w2 = w2;
      res_q.push_back(r);
      p1_health = (kind == 0) ? 3'($urandom_range(1, 3)) : ko_val();
      p2_health = (kind == 1) ? 3'($urandom_range(1, 3)) : ko_val();
    end else begin
      h1 = $urandom_range(1, 3);
      b1 = $urandom_range(0, 7);
      h2 = (kind == 4) ? h1 : $urandom_range(1, 3);
      b2 = (kind == 4) ? b1 : $urandom_range(0, 7);
      r.rw = judge(h1, h2, b1, b2);
      r.len = TD * RS;
      r.ko_chk = 1'b1;
      r.ko_exp = 1'b0;
      r.tmo = 1'b1;
      if (r.rw == 2'b01) w1 = (w1 < 3) ? w1 + 1 : 3;
      if (r.rw == 2'b10) w2 = (w2 < 3) ? w2 + 1 : 3;
      r.w1 = w1;
      r.w2 = w2;
      res_q.push_back(r);
      p1_health = 3'(h1);
      p2_health = 3'(h2);
      p1_block = 3'(b1);
      p2_block = 3'(b2);
    end
    last_rw = r.rw;
    done = (w1 >= RW) || (w2 >= RW) || (rn == MR);
    if (done) begin
      mr.mw = (w1 > w2) ? 2'b01 : (w2 > w1) ? 2'b10 : 2'b11;
      mr.rn = rn;
      mtch_q.push_back(mr);
    end else begin
      rn++;
      ir.rn = rn;
      ir.w1 = w1;
      ir.w2 = w2;
      ir.rw = last_rw;
      init_q.push_back(ir);
    end
    k = 0;
    while (fight_active && k < 20) begin
      tick();
      k++;
    end
    if (fight_active) abort("fight_end");
    start = 1'b0;
    p1_health = 3'd3;
    p2_health = 3'd3;
    p1_block = 3'($urandom_range(0, 7));
    p2_block = 3'($urandom_range(0, 7));
  endtask

  task automatic begin_match();
    init_t ir;
    w1 = 0;
    w2 = 0;
    rn = 1;
    last_rw = 2'b00;
    ir.rn = 1;
    ir.w1 = 0;
    ir.w2 = 0;
    ir.rw = 2'b00;
    init_q.push_back(ir);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // monitor
  initial begin
    bit    pf;
    bit    pko;
    bit    pmo;
    bit    pinit;
    int    len;
    res_t  r;
    init_t ir;
    mtch_t mr;
    pf = 0;
    pko = 0;
    pmo = 0;
    pinit = 0;
    len = 0;
    forever begin
      @(negedge clk);
      if (rst || mon_off) begin
        pf = 0;
        pko = 0;
        pmo = match_over;
        pinit = 0;
        len = 0;
      end else begin
        if (pinit) begin
          check("init_width", round_reset, 0);
          check("init_fight", fight_active, 1);
          check("init_timer", timer, RS);
        end
        pinit = round_reset;
        if (round_reset) begin
          check("init_pending", init_q.size() > 0, 1);
          if (init_q.size() > 0) begin
            ir = init_q.pop_front();
            check("init_round_num", round_num, ir.rn);
            check("init_p1_wins", p1_wins, ir.w1);
            check("init_p2_wins", p2_wins, ir.w2);
            check("init_round_winner", round_winner, ir.rw);
            check("init_match_over", match_over, 0);
            check("init_match_winner", match_winner, 0);
          end
        end
        if (fight_active) len++;
        if (pf && !fight_active) begin
          check("res_pending", res_q.size() > 0, 1);
          if (res_q.size() > 0) begin
            r = res_q.pop_front();
            check("round_winner", round_winner, r.rw);
            check("p1_wins", p1_wins, r.w1);
            check("p2_wins", p2_wins, r.w2);
            check("fight_len", len, r.len);
            if (r.ko_chk) check("ko_pulse", pko, r.ko_exp);
            if (r.tmo) check("timeout_timer", timer, 0);
          end
          len = 0;
        end
        if (!pmo && match_over) begin
          check("match_pending", mtch_q.size() > 0, 1);
          if (mtch_q.size() > 0) begin
            mr = mtch_q.pop_front();
            check("match_winner", match_winner, mr.mw);
            check("match_round_num", round_num, mr.rn);
          end
        end
        pf = fight_active;
        pko = ko;
        pmo = match_over;
      end
    end
  end

  task automatic check_reset_vals(string tag);
    check({tag, "_fight_active"}, fight_active, 0);
    check({tag, "_round_reset"}, round_reset, 0);
    check({tag, "_ko"}, ko, 0);
    check({tag, "_timer"}, timer, RS);
    check({tag, "_round_num"}, round_num, 0);
    check({tag, "_p1_wins"}, p1_wins, 0);
    check({tag, "_p2_wins"}, p2_wins, 0);
    check({tag, "_round_winner"}, round_winner, 0);
    check({tag, "_match_over"}, match_over, 0);
    check({tag, "_match_winner"}, match_winner, 0);
  endtask

  // stimulus
  initial begin
    bit done;
    int kind;
    int k;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("idle_no_start", fight_active, 0);
    for (int m = 0; m < 6; m++) begin
      begin_match();
      done = 1'b0;
      while (!done) begin
        unique case (m)
          1: kind = ($urandom_range(0, 1) == 0) ? 2 : 4;
          2: kind = 1;
          3: kind = 0;
          default: kind = $urandom_range(0, 4);
        endcase
        run_round(kind, done);
      end
      k = 0;
      while (!match_over && k < 40) begin
        tick();
        k++;
      end
      if (!match_over) abort("match_over");
      repeat ($urandom_range(0, 3)) tick();
    end
    begin_match();
    run_round(0, done);
    k = 0;
    while (!fight_active && k < 20) begin
      tick();
      k++;
    end
    if (!fight_active) abort("last_fight");
    mon_off = 1'b1;
`ifdef ROUND_PAUSE_EN
    begin
      logic [6:0] t0;
      t0 = timer;
      pause = 1'b1;
      repeat (20) tick();
      check("pause_timer", timer, t0);
      check("pause_fight_active", fight_active, 0);
      pause = 1'b0;
      tick();
      check("resume_fight_active", fight_active, 1);
    end
`endif
    tick();
    check("pre_abort_p1_wins", p1_wins, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("abort");
    check("res_q_drained", res_q.size(), 0);
    check("init_q_drained", init_q.size(), 0);
    check("mtch_q_drained", mtch_q.size(), 0);
    finish_test();
  end

  initial begin
    #200000;
    abort("global_timeout");
  end

endmodule
